// File: rtl/seg7_pattern_decoder_if.sv
// Segment-line monitor bus: the display side drives a..g, the decoder reports what it saw.
interface seg7_pattern_decoder_if #(
    parameter int unsigned CNT_W = 8
);
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             e;
    logic             f;
    logic             g;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             pattern_err;
    logic             blank;
    logic             locked;
    logic [CNT_W-1:0] change_cnt;

    modport master (
        output a, b, c, d, e, f, g,
        input  digit, digit_valid, pattern_err, blank, locked, change_cnt
    );

    modport slave (
        input  a, b, c, d, e, f, g,
        output digit, digit_valid, pattern_err, blank, locked, change_cnt
    );
endinterface

// File: rtl/seg7_pattern_decoder.sv
// Reads back active-low 7-segment lines, qualifies them for stability and
// recovers the displayed hex digit, flagging blanks and illegal patterns.
module seg7_pattern_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    seg7_pattern_decoder_if.slave  bus
);

    localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [6:0] PatBlank = 7'b1111111;

    typedef enum logic [0:0] {StSettle, StLocked} state_e;

    state_e           state_q;
    logic [SW-1:0]    stab_cnt_q;
    logic [6:0]       seg_meta_q;
    logic [6:0]       seg_s_q;
    logic [6:0]       seg_prev_q;
    logic [2:0]       fill_q;
    logic [6:0]       last_pat_q;
    logic             last_vld_q;
    logic [3:0]       digit_q;
    logic             digit_valid_q;
    logic             pattern_err_q;
    logic             blank_q;
    logic             locked_q;
    logic [CNT_W-1:0] change_cnt_q;

    logic [6:0]       seg_in;
    logic [3:0]       dec_digit;
    logic             dec_legal;
    logic             seg_changed;
    logic             pat_new;

    assign seg_in = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};

    // seg_prev only counts once it holds a post-reset sample, so a pattern present
    // across reset pays the same qualification latency as any other change.
    assign seg_changed = (seg_s_q != seg_prev_q) || !fill_q[2];
    assign pat_new     = !last_vld_q || (seg_s_q != last_pat_q);

    // Active-low segment table decode of the synchronized pattern.
    always_comb begin
        dec_digit = 4'h0;
        dec_legal = 1'b1;
        case (seg_s_q)
            7'b0000001: dec_digit = 4'h0;
            7'b1001111: dec_digit = 4'h1;
            7'b0010010: dec_digit = 4'h2;
            7'b0000110: dec_digit = 4'h3;
            7'b1001100: dec_digit = 4'h4;
            7'b0100100: dec_digit = 4'h5;
            7'b0100000: dec_digit = 4'h6;
            7'b0001111: dec_digit = 4'h7;
            7'b0000000: dec_digit = 4'h8;
            7'b0000100: dec_digit = 4'h9;
            7'b0001000: dec_digit = 4'hA;
            7'b1100000: dec_digit = 4'hB;
            7'b0110001: dec_digit = 4'hC;
            7'b1000010: dec_digit = 4'hD;
            7'b0110000: dec_digit = 4'hE;
            7'b0111000: dec_digit = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    // Synchronizer, stability FSM and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_meta_q    <= PatBlank;
            seg_s_q       <= PatBlank;
            seg_prev_q    <= PatBlank;
            fill_q        <= '0;
            state_q       <= StSettle;
            stab_cnt_q    <= '0;
            last_pat_q    <= PatBlank;
            last_vld_q    <= 1'b0;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
            blank_q       <= 1'b0;
            locked_q      <= 1'b0;
            change_cnt_q  <= '0;
        end else begin
            seg_meta_q    <= seg_in;
            seg_s_q       <= seg_meta_q;
            seg_prev_q    <= seg_s_q;
            fill_q        <= {fill_q[1:0], 1'b1};
            digit_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;

            if (seg_changed) begin
                stab_cnt_q <= '0;
                state_q    <= StSettle;
                locked_q   <= 1'b0;
            end else if (state_q == StSettle) begin
                if (stab_cnt_q == SW'(STABLE_CYCLES - 1)) begin
                    state_q    <= StLocked;
                    locked_q   <= 1'b1;
                    last_pat_q <= seg_s_q;
                    last_vld_q <= 1'b1;
                    if (pat_new) begin
                        if (dec_legal) begin
                            digit_q       <= dec_digit;
                            digit_valid_q <= 1'b1;
                            change_cnt_q  <= change_cnt_q + CNT_W'(1);
                            blank_q       <= 1'b0;
                        end else if (seg_s_q == PatBlank) begin
                            blank_q <= 1'b1;
                        end else begin
                            pattern_err_q <= 1'b1;
                        end
                    end
                end else begin
                    stab_cnt_q <= stab_cnt_q + SW'(1);
                end
            end
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.pattern_err = pattern_err_q;
    assign bus.blank       = blank_q;
    assign bus.locked      = locked_q;
    assign bus.change_cnt  = change_cnt_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Bench for seg7_pattern_decoder: run-length reference model over the raw input
// samples, checked every cycle, plus directed scenarios and random stimulus.
module tb_seg7_pattern_decoder;

    localparam int unsigned S     = 4;
    localparam int unsigned CW    = 4;
    localparam int unsigned RCAP  = S + 2;

    localparam logic [6:0] TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seg7_pattern_decoder_if #(.CNT_W(CW)) bus ();

    seg7_pattern_decoder #(
        .STABLE_CYCLES (S),
        .CNT_W         (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state
    logic [3:0]    m_digit;
    logic          m_valid;
    logic          m_err;
    logic          m_blank;
    logic          m_locked;
    logic [CW-1:0] m_cnt;
    logic [6:0]    m_last;
    logic          m_last_vld;
    int unsigned   r1, r2;     // run length of samples taken one and two edges ago
    logic [6:0]    p1, p2;     // those samples

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] p);
        {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = p;
    endtask

    // kind: 0 legal digit, 1 blank, 2 illegal
    function automatic int kind_of(input logic [6:0] p);
        if (p == 7'h7F) return 1;
        for (int i = 0; i < 16; i++) if (TBL[i] == p) return 0;
        return 2;
    endfunction

    function automatic logic [3:0] digit_of(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (TBL[i] == p) return 4'(i);
        return 4'h0;
    endfunction

    // Reference model update on every edge, then compare all outputs
    initial forever begin
        logic [6:0]  cur;
        int unsigned run;
        @(posedge clk);
        cur = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};
        if (rst) begin
            m_digit = 0; m_valid = 0; m_err = 0; m_blank = 0; m_locked = 0; m_cnt = 0;
            m_last = 7'h7F; m_last_vld = 0; r1 = 0; r2 = 0; p1 = 7'h7F; p2 = 7'h7F;
        end else begin
            run = (r1 != 0 && cur == p1) ? ((r1 >= RCAP) ? RCAP : r1 + 1) : 1;
            m_valid = 0;
            m_err   = 0;
            // A pattern is accepted when its run of equal samples reaches S+1,
            // seen through the two-flop synchronizer delay.
            if (r2 == S + 1 && (!m_last_vld || p2 != m_last)) begin
                case (kind_of(p2))
                    0: begin
                        m_digit = digit_of(p2); m_valid = 1; m_cnt = m_cnt + 1'b1; m_blank = 0;
                    end
                    1: m_blank = 1;
                    default: m_err = 1;
                endcase
            end
            if (r2 == S + 1) begin
                m_last = p2;
                m_last_vld = 1;
            end
            m_locked = (r2 >= S + 1);
            r2 = r1; p2 = p1; r1 = run; p1 = cur;
        end
        #1;
        chk("digit",       32'(bus.digit),       32'(m_digit));
        chk("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
        chk("pattern_err", 32'(bus.pattern_err), 32'(m_err));
        chk("blank",       32'(bus.blank),       32'(m_blank));
        chk("locked",      32'(bus.locked),      32'(m_locked));
        chk("change_cnt",  32'(bus.change_cnt),  32'(m_cnt));
    end

    // Wait n edges, landing just after the compare of the last one
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_at_negedge(input logic [6:0] p);
        @(negedge clk);
        drive(p);
    endtask

    initial begin
        drive(7'h7F);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Blank held through reset: locks on the 7th edge after release (k+6)
        edges(6);
        chk("pin_blank_not_yet_locked", 32'(bus.locked), 32'd0);
        edges(1);
        chk("pin_blank_locked", 32'(bus.locked), 32'd1);
        chk("pin_blank_level",  32'(bus.blank),  32'd1);
        chk("pin_blank_cnt",    32'(bus.change_cnt), 32'd0);

        // Digit 0 then digit 1, each pulse exactly 6 edges after first sample
        set_at_negedge(7'b0000001);
        edges(6);
        chk("pin_d0_early", 32'(bus.digit_valid), 32'd0);
        edges(1);
        chk("pin_d0_pulse", 32'(bus.digit_valid), 32'd1);
        chk("pin_d0_digit", 32'(bus.digit), 32'd0);
        chk("pin_d0_blank", 32'(bus.blank), 32'd0);
        set_at_negedge(7'b1001111);
        edges(7);
        chk("pin_d1_pulse", 32'(bus.digit_valid), 32'd1);
        chk("pin_d1_digit", 32'(bus.digit), 32'd1);
        chk("pin_d1_cnt",   32'(bus.change_cnt), 32'd2);

        // Digit 3 with a 2-cycle glitch to 8: relock, no pulse
        set_at_negedge(7'b0000110);
        edges(10);
        set_at_negedge(7'b0000000);
        set_at_negedge(7'b0000000);
        set_at_negedge(7'b0000110);
        edges(3);
        chk("pin_glitch_unlocked", 32'(bus.locked), 32'd0);
        edges(10);
        chk("pin_glitch_relocked", 32'(bus.locked), 32'd1);
        chk("pin_glitch_digit",    32'(bus.digit), 32'd3);
        chk("pin_glitch_cnt",      32'(bus.change_cnt), 32'd3);

        // Illegal pattern, then same pattern again after a glitch
        set_at_negedge(7'b1010101);
        edges(7);
        chk("pin_illegal_err",   32'(bus.pattern_err), 32'd1);
        chk("pin_illegal_digit", 32'(bus.digit), 32'd3);
        edges(3);
        set_at_negedge(7'b0000000);
        set_at_negedge(7'b1010101);
        edges(12);

        // Walk all 16 digits; 4-bit counter goes 3 -> 19 mod 16 = 3, wrapping past 15
        for (int i = 0; i < 16; i++) begin
            set_at_negedge(TBL[i]);
            edges(8);
        end
        chk("pin_walk_digit", 32'(bus.digit), 32'd15);
        chk("pin_walk_cnt",   32'(bus.change_cnt), 32'd3);

        // Reset 3 cycles into qualifying digit 5
        set_at_negedge(7'b0100100);
        edges(3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("pin_rst_cnt",    32'(bus.change_cnt), 32'd0);
        chk("pin_rst_digit",  32'(bus.digit), 32'd0);
        chk("pin_rst_locked", 32'(bus.locked), 32'd0);
        edges(6);
        chk("pin_d5_early", 32'(bus.digit_valid), 32'd0);
        edges(1);
        chk("pin_d5_pulse", 32'(bus.digit_valid), 32'd1);
        chk("pin_d5_digit", 32'(bus.digit), 32'd5);
        chk("pin_d5_cnt",   32'(bus.change_cnt), 32'd1);

        // Random patterns, hold times and occasional resets
        for (int n = 0; n < 400; n++) begin
            int unsigned sel;
            logic [6:0]  p;
            sel = $urandom_range(0, 9);
            if (sel <= 5)      p = TBL[$urandom_range(0, 15)];
            else if (sel == 6) p = 7'h7F;
            else               p = 7'($urandom);
            @(negedge clk);
            drive(p);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 9)) @(negedge clk);
        end
        edges(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
